// File: rtl/watch_pkg.sv
// Shared definitions for the watch mode/time-set controller.
//   mode_e        : set_mode encoding, also used directly as the controller state
//   *_DEF         : default timing parameters
//   *_W_DEF       : counter widths for the default timing parameters
//   cnt_width()   : bits needed to hold a count of 0..max_val
//   next_mode()   : mode sequence TIME -> SET_HOUR -> SET_MIN -> STOPWATCH -> TIME
// Optional feature macro used by this block: AUTO_REPEAT_EN
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_TIME      = 2'd0,
        MODE_SET_HOUR  = 2'd1,
        MODE_SET_MIN   = 2'd2,
        MODE_STOPWATCH = 2'd3
    } mode_e;

    localparam int HOLD_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 12_500_000;
    localparam int TIMEOUT_SEC_DEF   = 10;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int HOLD_W_DEF    = $clog2(HOLD_CYCLES_DEF + 1);
    localparam int TIMEOUT_W_DEF = $clog2(TIMEOUT_SEC_DEF + 1);

    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] v;
        v = m;
        v = v + 2'd1;
        return mode_e'(v);
    endfunction

endpackage

// File: rtl/watch_set_ctrl_btn_edge_repeat.sv
// btn_edge_repeat: rising-edge detector for one debounced button, with an
// optional hold/auto-repeat generator (macro AUTO_REPEAT_EN).
// Ports:
//   clk, reset_n : clock, async active-low reset
//   btn          : debounced button level
//   rep_allow    : 1 = auto-repeat may run; 0 cancels any repeat in progress
//   press        : combinational 1-cycle press event (edge or repeat)
// With auto-repeat, the cycle of the edge counts as the first held cycle, so
// the first repeat lands on held cycle HOLD_CYCLES (HOLD_CYCLES >= 2 assumed).
module btn_edge_repeat
    import watch_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    input  logic rep_allow,
    output logic press
);

    logic btn_prev_q;
    logic btn_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) btn_prev_q <= 1'b0;
        else          btn_prev_q <= btn;
    end

    assign btn_edge = btn & ~btn_prev_q;

`ifdef AUTO_REPEAT_EN
    localparam int CNT_W = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_fire;

    always_comb begin
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        rep_fire = 1'b0;
        if (!btn || !rep_allow) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (btn_edge) begin
            armed_d = 1'b1;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else if (armed_q) begin
            if (cnt_q == CNT_W'(1)) begin
                rep_fire = 1'b1;
                cnt_d    = CNT_W'(REPEAT_CYCLES);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = btn_edge | rep_fire;
`else
    // Single press per edge; the repeat controls have no effect in this build.
    logic unused_ok;
    assign unused_ok = rep_allow ^ (HOLD_CYCLES > 0) ^ (REPEAT_CYCLES > 0);
    assign press     = btn_edge;
`endif

endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: mode sequencing and time-set pulse generation for the watch.
// Optional feature macro: AUTO_REPEAT_EN (held up/down auto-repeat in SET_*).
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   tick_1hz                  : 1 Hz level, rising edge detected here
//   btn_mode, btn_up, btn_down: debounced button levels
//   min_inc/min_dec/hour_inc/hour_dec : registered 1-cycle adjust pulses
//   clock_enable              : 1 = display time, 0 = display stopwatch
//   set_mode                  : current mode (watch_pkg::mode_e encoding)
//   blink                     : blank the field being set
//   sw_run, sw_clear          : stopwatch run level / 1-cycle clear pulse
//
// state          | meaning
// MODE_TIME      | normal time display, up/down ignored
// MODE_SET_HOUR  | up/down adjust hours, blink + inactivity timeout active
// MODE_SET_MIN   | up/down adjust minutes, blink + inactivity timeout active
// MODE_STOPWATCH | up toggles run, down clears when stopped
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int TIMEOUT_SEC   = TIMEOUT_SEC_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       min_inc,
    output logic       min_dec,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       clock_enable,
    output logic [1:0] set_mode,
    output logic       blink,
    output logic       sw_run,
    output logic       sw_clear
);

    localparam int TO_W = cnt_width(TIMEOUT_SEC);

    mode_e           state_q, state_d;
    logic            mode_prev_q, tick_prev_q;
    logic            lock_q, lock_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            blink_q, blink_d;
    logic            sw_run_q, sw_run_d;
    logic            sw_clear_q, sw_clear_d;
    logic            min_inc_q, min_inc_d, min_dec_q, min_dec_d;
    logic            hour_inc_q, hour_inc_d, hour_dec_q, hour_dec_d;

    logic mode_edge, tick_rise, both, in_set;
    logic rep_allow, up_press, dn_press, up_act, dn_act, btn_evt;

    assign mode_edge = btn_mode & ~mode_prev_q;
    assign tick_rise = tick_1hz & ~tick_prev_q;
    assign both      = btn_up & btn_down;
    assign in_set    = (state_q == MODE_SET_HOUR) || (state_q == MODE_SET_MIN);
    // Once both were held, repeat stays off until both are released.
    assign rep_allow = in_set & ~lock_q & ~both & ~mode_edge;

    btn_edge_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_up (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn_up),
        .rep_allow (rep_allow),
        .press     (up_press)
    );

    btn_edge_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_dn (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn_down),
        .rep_allow (rep_allow),
        .press     (dn_press)
    );

    // Mode edge wins over up/down; both held produces nothing.
    assign up_act  = up_press & ~both & ~mode_edge;
    assign dn_act  = dn_press & ~both & ~mode_edge;
    assign btn_evt = mode_edge | up_press | dn_press;

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        to_cnt_d   = to_cnt_q;
        blink_d    = blink_q;
        sw_run_d   = sw_run_q;
        sw_clear_d = 1'b0;
        min_inc_d  = 1'b0;
        min_dec_d  = 1'b0;
        hour_inc_d = 1'b0;
        hour_dec_d = 1'b0;

        if (both)                      lock_d = 1'b1;
        else if (!btn_up && !btn_down) lock_d = 1'b0;

        if (mode_edge) begin
            state_d = next_mode(state_q);
        end else if (in_set && tick_rise && !btn_evt && to_cnt_q == TO_W'(1)) begin
            state_d = MODE_TIME;
        end

        case (state_q)
            MODE_SET_HOUR: begin
                hour_inc_d = up_act;
                hour_dec_d = dn_act;
            end
            MODE_SET_MIN: begin
                min_inc_d = up_act;
                min_dec_d = dn_act;
            end
            MODE_STOPWATCH: begin
                if (up_act) sw_run_d = ~sw_run_q;
                sw_clear_d = dn_act & ~sw_run_q;
            end
            default: ;
        endcase

        // Down-counter of remaining inactive seconds, reloaded on activity.
        if (state_d != state_q || btn_evt) begin
            to_cnt_d = TO_W'(TIMEOUT_SEC);
        end else if (in_set && tick_rise) begin
            to_cnt_d = to_cnt_q - TO_W'(1);
        end

        if (state_d != state_q || !in_set) begin
            blink_d = 1'b0;
        end else if (tick_rise) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MODE_TIME;
            mode_prev_q <= 1'b0;
            tick_prev_q <= 1'b0;
            lock_q      <= 1'b0;
            to_cnt_q    <= '0;
            blink_q     <= 1'b0;
            sw_run_q    <= 1'b0;
            sw_clear_q  <= 1'b0;
            min_inc_q   <= 1'b0;
            min_dec_q   <= 1'b0;
            hour_inc_q  <= 1'b0;
            hour_dec_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode;
            tick_prev_q <= tick_1hz;
            lock_q      <= lock_d;
            to_cnt_q    <= to_cnt_d;
            blink_q     <= blink_d;
            sw_run_q    <= sw_run_d;
            sw_clear_q  <= sw_clear_d;
            min_inc_q   <= min_inc_d;
            min_dec_q   <= min_dec_d;
            hour_inc_q  <= hour_inc_d;
            hour_dec_q  <= hour_dec_d;
        end
    end

    assign set_mode     = state_q;
    assign clock_enable = (state_q != MODE_STOPWATCH);
    assign blink        = blink_q;
    assign sw_run       = sw_run_q;
    assign sw_clear     = sw_clear_q;
    assign min_inc      = min_inc_q;
    assign min_dec      = min_dec_q;
    assign hour_inc     = hour_inc_q;
    assign hour_dec     = hour_dec_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: stimulus pushes expected output events into a
// queue, a negedge monitor pops and compares whenever an output event occurs.
module tb_watch_set_ctrl;

    localparam int HOLD   = 20;
    localparam int REPEAT = 5;
    localparam int TMO    = 10;
`ifdef AUTO_REPEAT_EN
    localparam int REP_PULSES = 6;
`else
    localparam int REP_PULSES = 1;
`endif

    typedef enum int {EV_MODE, EV_RUN, EV_HINC, EV_HDEC, EV_MINC, EV_MDEC, EV_CLR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [1:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       min_inc, min_dec, hour_inc, hour_dec;
    logic       clock_enable, blink, sw_run, sw_clear;
    logic [1:0] set_mode;

    int  n_checks = 0;
    int  n_errors = 0;
    ev_t exp_q[$];
    logic       mon_on = 1'b0;
    logic [1:0] last_mode = 2'd0;
    logic       last_run = 1'b0;

    watch_set_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT),
        .TIMEOUT_SEC   (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_1hz     (tick_1hz),
        .btn_mode     (btn_mode),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .min_inc      (min_inc),
        .min_dec      (min_dec),
        .hour_inc     (hour_inc),
        .hour_dec     (hour_dec),
        .clock_enable (clock_enable),
        .set_mode     (set_mode),
        .blink        (blink),
        .sw_run       (sw_run),
        .sw_clear     (sw_clear)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input ev_kind_e k, input logic [1:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input logic [1:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d, required none (t=%0t)", k, v, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                n_errors++;
                $display("FAIL event: got kind=%0d val=%0d, required kind=%0d val=%0d (t=%0t)",
                         k, v, e.kind, e.val, $time);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (set_mode != last_mode) begin
                observe(EV_MODE, set_mode);
                chk("clock_enable", int'(clock_enable), int'(set_mode != 2'd3));
                last_mode = set_mode;
            end
            if (sw_run != last_run) begin
                observe(EV_RUN, {1'b0, sw_run});
                last_run = sw_run;
            end
            if (hour_inc) observe(EV_HINC, 2'd0);
            if (hour_dec) observe(EV_HDEC, 2'd0);
            if (min_inc)  observe(EV_MINC, 2'd0);
            if (min_dec)  observe(EV_MDEC, 2'd0);
            if (sw_clear) observe(EV_CLR, 2'd0);
        end
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_mode = v;
            1:       btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press(input int which, input int n);
        @(negedge clk);
        set_btn(which, 1'b1);
        repeat (n) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_set_mode", int'(set_mode), 0);
        chk("rst_clock_enable", int'(clock_enable), 1);
        chk("rst_pulses", int'({min_inc, min_dec, hour_inc, hour_dec, sw_clear}), 0);
        chk("rst_blink_run", int'({blink, sw_run}), 0);
        reset_n = 1'b1;
        mon_on  = 1'b1;
        repeat (2) @(negedge clk);

        // Mode cycle through all four modes
        expect_ev(EV_MODE, 2'd1); press(0, 1);
        expect_ev(EV_MODE, 2'd2); press(0, 1);
        expect_ev(EV_MODE, 2'd3); press(0, 3);
        expect_ev(EV_MODE, 2'd0); press(0, 1);

        // TIME: up/down ignored
        press(1, 2);
        press(2, 2);

        // SET_HOUR: 3 up, 1 down
        expect_ev(EV_MODE, 2'd1); press(0, 1);
        for (int i = 0; i < 3; i++) begin
            expect_ev(EV_HINC, 2'd0); press(1, 2);
        end
        expect_ev(EV_HDEC, 2'd0); press(2, 1);

        // Both up and down together: nothing
        @(negedge clk);
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (4) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (2) @(negedge clk);

        // Mode together with up: mode wins
        expect_ev(EV_MODE, 2'd2);
        @(negedge clk);
        btn_mode = 1'b1; btn_up = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0;
        repeat (2) @(negedge clk);

        // SET_MIN: up, down, then long hold
        expect_ev(EV_MINC, 2'd0); press(1, 1);
        expect_ev(EV_MDEC, 2'd0); press(2, 1);
        for (int i = 0; i < REP_PULSES; i++) expect_ev(EV_MINC, 2'd0);
        press(1, 40);
        repeat (3) @(negedge clk);

        // Timeout: 9 ticks, activity, 9 ticks stay, 10th exits
        for (int i = 0; i < 9; i++) tick();
        chk("blink_after_9", int'(blink), 1);
        expect_ev(EV_MINC, 2'd0); press(1, 1);
        for (int i = 0; i < 9; i++) tick();
        chk("no_timeout_9", int'(set_mode), 2);
        chk("blink_after_18", int'(blink), 0);
        expect_ev(EV_MODE, 2'd0);
        tick();
        @(negedge clk);
        chk("timeout_mode", int'(set_mode), 0);
        chk("blink_exit", int'(blink), 0);

        // STOPWATCH
        expect_ev(EV_MODE, 2'd1); press(0, 1);
        expect_ev(EV_MODE, 2'd2); press(0, 1);
        expect_ev(EV_MODE, 2'd3); press(0, 1);
        expect_ev(EV_RUN, 2'd1);  press(1, 1);
        press(2, 1);
        expect_ev(EV_RUN, 2'd0);  press(1, 1);
        expect_ev(EV_CLR, 2'd0);  press(2, 1);
        expect_ev(EV_RUN, 2'd1);  press(1, 1);
        expect_ev(EV_MODE, 2'd0); press(0, 1);
        chk("sw_run_background", int'(sw_run), 1);

        // Reset in the middle of a hold in SET_HOUR
        expect_ev(EV_MODE, 2'd1); press(0, 1);
        expect_ev(EV_HINC, 2'd0);
        @(negedge clk);
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        expect_ev(EV_MODE, 2'd0);
        expect_ev(EV_RUN, 2'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_set_mode", int'(set_mode), 0);
        chk("async_clock_enable", int'(clock_enable), 1);
        chk("async_sw_run", int'(sw_run), 0);
        chk("async_pulses", int'({min_inc, min_dec, hour_inc, hour_dec, sw_clear}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        btn_up = 1'b0;
        repeat (5) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
